// File: rtl/glyph_matcher.sv
// rtl/glyph_matcher.sv - 16x16 digit glyph recognizer by minimum Hamming distance
//
// Captures a 16-row monochrome bitmap, then scans NUM_GLYPHS stored glyphs
// row by row through an external combinational ROM mux, accumulating the
// Hamming distance per glyph and reporting the closest one.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    captured row handshake, in_row = row data (bit 0 leftmost)
//   rom_sel/rom_addr     glyph index / row address presented to the ROM mux
//   rom_row              ROM row data, combinational from rom_sel/rom_addr
//   res_valid            one-cycle pulse when the result registers update
//   res_digit/res_dist   closest glyph index and its distance (0..256)
//   res_match            res_dist <= MATCH_THRESH
module glyph_matcher #(
    parameter int NUM_GLYPHS   = 10,
    parameter int MATCH_THRESH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_row,
    output logic [3:0]  rom_sel,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_row,
    output logic        res_valid,
    output logic [3:0]  res_digit,
    output logic [8:0]  res_dist,
    output logic        res_match
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_GLYPH = 4'(NUM_GLYPHS - 1);
    localparam logic [8:0] THRESH     = 9'(MATCH_THRESH);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] frame_buf [16];
    logic [3:0]  glyph;
    logic [3:0]  row;
    logic [8:0]  acc;
    logic [8:0]  best;
    logic [3:0]  best_idx;

    logic [15:0] diff;
    logic [4:0]  d;
    logic [8:0]  total;

    // Per-row distance of the current ROM row against the captured row.
    always_comb begin
        diff = rom_row ^ frame_buf[row];
        d    = '0;
        for (int i = 0; i < 16; i++) begin
            d = d + 5'(diff[i]);
        end
        total = acc + 9'(d);
    end

    assign in_ready = (state == IDLE) || (state == LOAD);

    // glyph/row are held at 0 outside SCAN, so they drive the ROM mux directly.
    assign rom_sel  = glyph;
    assign rom_addr = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            for (int i = 0; i < 16; i++) begin
                frame_buf[i] <= '0;
            end
            glyph     <= '0;
            row       <= '0;
            acc       <= '0;
            best      <= '1;
            best_idx  <= '0;
            res_valid <= 1'b0;
            res_digit <= '0;
            res_dist  <= '0;
            res_match <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frame_buf[0] <= in_row;
                        cnt          <= 4'd1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        frame_buf[cnt] <= in_row;
                        if (cnt == 4'd15) begin
                            cnt      <= '0;
                            glyph    <= '0;
                            row      <= '0;
                            acc      <= '0;
                            best     <= '1;
                            best_idx <= '0;
                            state    <= SCAN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                SCAN: begin
                    if (row != 4'd15) begin
                        acc <= total;
                        row <= row + 4'd1;
                    end else begin
                        // Strict compare: on a tie the earlier (lower) glyph wins.
                        if (total < best) begin
                            best     <= total;
                            best_idx <= glyph;
                        end
                        acc <= '0;
                        row <= '0;
                        if (glyph == LAST_GLYPH) begin
                            glyph <= '0;
                            state <= DONE;
                        end else begin
                            glyph <= glyph + 4'd1;
                        end
                    end
                end
                DONE: begin
                    res_valid <= 1'b1;
                    res_digit <= best_idx;
                    res_dist  <= best;
                    res_match <= (best <= THRESH);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_matcher.sv
// tb/tb_glyph_matcher.sv - directed self-checking bench for glyph_matcher
module tb_glyph_matcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_row;
    logic [3:0]  rom_sel;
    logic [3:0]  rom_addr;
    logic [15:0] rom_row;
    logic        res_valid;
    logic [3:0]  res_digit;
    logic [8:0]  res_dist;
    logic        res_match;

    int tests_run    = 0;
    int tests_failed = 0;
    logic tie_mode   = 1'b0;
    logic [15:0] cur_frame [16];

    always #5 clk = ~clk;

    glyph_matcher #(.NUM_GLYPHS(10), .MATCH_THRESH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_row   (rom_row),
        .res_valid (res_valid),
        .res_digit (res_digit),
        .res_dist  (res_dist),
        .res_match (res_match)
    );

    // Stub ROM: rows 10 and 11 are all zero in every glyph (32 common zeros);
    // glyph g additionally has row g zeroed (row 7 of glyph 7 only half zero).
    // Zero counts: glyph 7 = 40, others = 48. Pairwise distances >= 24.
    // In tie mode glyph 5 is a copy of glyph 2.
    function automatic logic [15:0] rom_fn(input logic [3:0] g, input logic [3:0] r, input logic tie);
        logic [3:0] gg;
        gg = (tie && g == 4'd5) ? 4'd2 : g;
        if (gg > 4'd9)                 return 16'hFFFF;
        if (r == 4'd10 || r == 4'd11)  return 16'h0000;
        if (r == gg)                   return (gg == 4'd7) ? 16'h00FF : 16'h0000;
        return 16'hFFFF;
    endfunction

    assign rom_row = rom_fn(rom_sel, rom_addr, tie_mode);

    task automatic load_glyph(input logic [3:0] g);
        for (int r = 0; r < 16; r++) cur_frame[r] = rom_fn(g, 4'(r), 1'b0);
    endtask

    // Streams rows 0..nrows-1 of cur_frame; returns 1ns after the last accept edge.
    task automatic send_frame(input int nrows, input bit gaps);
        for (int r = 0; r < nrows; r++) begin
            if (gaps && (r % 3 == 1)) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_row   = 16'hA5A5;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_row   = cur_frame[r];
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_row   = 16'h0000;
    endtask

    // Counts edges after the last accept until res_valid is seen (0 on timeout).
    // With offer set, beats are presented during the scan and in_ready highs counted.
    task automatic wait_result(input bit offer, output int lat, output int ready_seen);
        lat = 0;
        ready_seen = 0;
        for (int m = 1; m <= 400; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid) begin
                lat = m;
                break;
            end
            if (offer && m < 159) begin
                if (in_ready) ready_seen++;
                in_valid = 1'b1;
                in_row   = 16'h0000;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_row = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match} !==
            {1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 9'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b sel=%0d addr=%0d rv=%b dig=%0d dist=%0d m=%b, expected 1 0 0 0 0 0 0",
                     in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact;
        int lat, rs;
        load_glyph(4'd6);
        send_frame(16, 1'b0);
        wait_result(1'b0, lat, rs);
        tests_run++;
        if (lat !== 161) begin
            tests_failed++;
            $display("FAIL exact_latency: got %0d expected 161", lat);
        end
        tests_run++;
        if ({res_digit, res_dist, res_match} !== {4'd6, 9'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL exact_result: digit=%0d dist=%0d match=%b expected 6 0 1", res_digit, res_dist, res_match);
        end
        @(negedge clk);
        tests_run++;
        if (res_valid !== 1'b0 || res_digit !== 4'd6) begin
            tests_failed++;
            $display("FAIL exact_pulse_hold: res_valid=%b digit=%0d expected 0 6", res_valid, res_digit);
        end
    endtask

    task automatic test_noisy;
        int lat, rs;
        load_glyph(4'd3);
        cur_frame[0] = cur_frame[0] ^ 16'h001F;
        send_frame(16, 1'b0);
        wait_result(1'b0, lat, rs);
        tests_run++;
        if (lat == 0 || {res_digit, res_dist, res_match} !== {4'd3, 9'd5, 1'b1}) begin
            tests_failed++;
            $display("FAIL noisy_result: lat=%0d digit=%0d dist=%0d match=%b expected 3 5 1", lat, res_digit, res_dist, res_match);
        end
    endtask

    task automatic test_tie;
        int lat, rs;
        tie_mode = 1'b1;
        load_glyph(4'd2);
        send_frame(16, 1'b0);
        wait_result(1'b0, lat, rs);
        tests_run++;
        if (lat == 0 || {res_digit, res_dist} !== {4'd2, 9'd0}) begin
            tests_failed++;
            $display("FAIL tie_lower_index: lat=%0d digit=%0d dist=%0d expected 2 0", lat, res_digit, res_dist);
        end
        tie_mode = 1'b0;
    endtask

    task automatic test_all_ones;
        int lat, rs;
        for (int r = 0; r < 16; r++) cur_frame[r] = 16'hFFFF;
        send_frame(16, 1'b0);
        wait_result(1'b1, lat, rs);
        tests_run++;
        if (rs !== 0) begin
            tests_failed++;
            $display("FAIL scan_in_ready: in_ready high %0d cycles, expected 0", rs);
        end
        tests_run++;
        if (lat !== 161) begin
            tests_failed++;
            $display("FAIL all_ones_latency: got %0d expected 161", lat);
        end
        tests_run++;
        if ({res_digit, res_dist, res_match} !== {4'd7, 9'd40, 1'b0}) begin
            tests_failed++;
            $display("FAIL all_ones_result: digit=%0d dist=%0d match=%b expected 7 40 0", res_digit, res_dist, res_match);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_gaps;
        int lat, rs;
        load_glyph(4'd8);
        send_frame(16, 1'b1);
        wait_result(1'b0, lat, rs);
        tests_run++;
        if (lat !== 161 || {res_digit, res_dist, res_match} !== {4'd8, 9'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL gaps_result: lat=%0d digit=%0d dist=%0d match=%b expected 161 8 0 1", lat, res_digit, res_dist, res_match);
        end
    endtask

    task automatic test_reset_mid;
        int lat, rs, pulses;
        // Reset during load.
        load_glyph(4'd4);
        send_frame(7, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match} !==
            {1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 9'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_in_load: rdy=%b sel=%0d addr=%0d rv=%b dig=%0d dist=%0d m=%b, expected 1 0 0 0 0 0 0",
                     in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset during scan: after 50 scan edges the scan is at glyph 3, row 2.
        send_frame(16, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        tests_run++;
        if (rom_sel !== 4'd3 || rom_addr !== 4'd2 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL scan_position: sel=%0d addr=%0d rdy=%b expected 3 2 0", rom_sel, rom_addr, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match} !==
            {1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 9'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_in_scan: rdy=%b sel=%0d addr=%0d rv=%b dig=%0d dist=%0d m=%b, expected 1 0 0 0 0 0 0",
                     in_ready, rom_sel, rom_addr, res_valid, res_digit, res_dist, res_match);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_result: %0d res_valid pulses, expected 0", pulses);
        end
        load_glyph(4'd1);
        send_frame(16, 1'b0);
        wait_result(1'b0, lat, rs);
        tests_run++;
        if (lat !== 161 || {res_digit, res_dist, res_match} !== {4'd1, 9'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL after_reset_result: lat=%0d digit=%0d dist=%0d match=%b expected 161 1 0 1", lat, res_digit, res_dist, res_match);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_noisy();
        test_tie();
        test_all_ones();
        test_gaps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
